// File: rtl/dmem_responder_if.sv
// Core-to-data-memory request/response bundle.
// Master is the core MEM stage, slave is the responder.
interface dmem_responder_if;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic [31:0] DAD;
  logic [31:0] DDT_in;
  logic [31:0] DDT_out;
  logic        ERR;
  logic [1:0]  err_status;

  modport master (
    output MREQ, WRITE, SIZE, DAD, DDT_in,
    input  DDT_out, ERR, err_status
  );

  modport slave (
    input  MREQ, WRITE, SIZE, DAD, DDT_in,
    output DDT_out, ERR, err_status
  );
endinterface

// File: rtl/dmem_responder.sv
// Zero-latency data RAM with byte-enable stores, plus a cycle
// counter and sticky W1C error status in a small MMIO window.
module dmem_responder #(
  parameter logic [31:0] DMEM_BASE   = 32'h0002_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [31:0]   r_cnt;
  logic [1:0]    r_err;

  logic [29:0]   w_woff;
  logic [AW-1:0] w_idx;
  logic          w_ram;
  logic          w_mmio;
  logic          w_is_b;
  logic          w_is_h;
  logic          w_is_w;
  logic          w_mis;
  logic          w_oor;
  logic          w_fault;
  logic          w_req;
  logic          w_ld;
  logic          w_st;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_mask;
  logic [31:0]   w_word;
  logic [1:0]    w_set;
  logic [1:0]    w_clr;

  // Below-base addresses wrap to a huge word offset and miss.
  assign w_woff = bus.DAD[31:2] - DMEM_BASE[31:2];
  assign w_ram  = (w_woff[29:AW] == '0);
  assign w_idx  = w_woff[AW-1:0];
  assign w_mmio = (bus.DAD[31:3] == MMIO_BASE[31:3]);

  assign w_is_b = (bus.SIZE == 2'b00);
  assign w_is_h = (bus.SIZE == 2'b01);
  assign w_is_w = (bus.SIZE == 2'b10);

  assign w_mis = (w_is_h & bus.DAD[0])
               | (w_is_w & |bus.DAD[1:0])
               | (bus.SIZE == 2'b11)
               | (w_mmio & ~w_is_w);
  assign w_oor   = ~w_ram & ~w_mmio;
  assign w_fault = w_mis | w_oor;

  assign w_req = rst & bus.MREQ;
  assign w_ld  = w_req & ~bus.WRITE & ~w_fault;
  assign w_st  = w_req & bus.WRITE & ~w_fault;

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = bus.DDT_in;
    w_mask  = 32'h0000_0000;
    unique case (1'b1)
      w_is_b: begin
        w_be    = 4'b0001 << bus.DAD[1:0];
        w_wdata = {4{bus.DDT_in[7:0]}};
        w_mask  = 32'h0000_00FF;
      end
      w_is_h: begin
        w_be    = bus.DAD[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{bus.DDT_in[15:0]}};
        w_mask  = 32'h0000_FFFF;
      end
      w_is_w: begin
        w_be    = 4'b1111;
        w_mask  = 32'hFFFF_FFFF;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_word = r_mem[w_idx];
    if (w_mmio)
      w_word = bus.DAD[2] ? {30'b0, r_err} : r_cnt;
  end

  assign bus.DDT_out = w_ld
    ? ((w_word >> {bus.DAD[1:0], 3'b000}) & w_mask)
    : 32'h0000_0000;
  assign bus.ERR        = w_req & w_fault;
  assign bus.err_status = r_err;

  assign w_set = {w_req & w_oor, w_req & w_mis};
  assign w_clr = (w_st & w_mmio & bus.DAD[2])
    ? bus.DDT_in[1:0] : 2'b00;

  // RAM is never cleared; w_st already drops a store under reset.
  always_ff @(posedge clk) begin
    if (w_st & w_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i])
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 32'h0000_0000;
      r_err <= 2'b00;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      r_err <= (r_err & ~w_clr) | w_set;
    end
  end
endmodule
